sort_sched: RTL

SORT_SCHED -- requirements
Module: sort_sched

---
 rtl/sort_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sort_sched.sv
// Round-robin scheduler that shares one external sort engine among NUM_REQ requesters.
// A watchdog aborts a job whose engine never reports completion.
module sort_sched #(
    parameter int unsigned SIZE_DATA  = 8,
    parameter int unsigned NUMBER_ARR = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NUM_REQ-1:0]                      i_req,
    input  logic [NUM_REQ*NUMBER_ARR*SIZE_DATA-1:0] i_data,
    output logic [NUM_REQ-1:0]                      o_grant,
    output logic [NUM_REQ-1:0]                      o_done,
    output logic                                    o_err,
    output logic [NUMBER_ARR*SIZE_DATA-1:0]         o_data,
    output logic                                    o_busy,
    output logic                                    o_eng_start,
    output logic [NUMBER_ARR*SIZE_DATA-1:0]         o_eng_data,
    input  logic [NUMBER_ARR*SIZE_DATA-1:0]         i_eng_data,
    input  logic                                    i_eng_done
);

    localparam int unsigned ARR_W = SIZE_DATA * NUMBER_ARR;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [WD_W-1:0]    r_wd;
    logic [ARR_W-1:0]   r_job;
    logic [ARR_W-1:0]   r_data;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_err;
    logic               r_busy;
    logic               r_eng_start;

    logic [IDX_W:0]     w_cand;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [ARR_W-1:0]   w_sel_data;
    logic [IDX_W-1:0]   w_rr_next;
    logic [WD_W-1:0]    w_wd_inc;

    // Search for the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = (IDX_W+1)'(r_rr_ptr) + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (w_sel == IDX_W'(r)) begin
                w_sel_data = i_data[r*ARR_W +: ARR_W];
            end
        end
    end

    assign w_rr_next = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_wd_inc  = r_wd + WD_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_wd        <= '0;
            r_job       <= '0;
            r_data      <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            r_done      <= '0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner     <= w_sel;
                        r_job       <= w_sel_data;
                        r_grant     <= NUM_REQ'(1) << w_sel;
                        r_busy      <= 1'b1;
                        r_eng_start <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Engine completion beats a watchdog expiry landing on the same edge.
                    r_wd <= w_wd_inc;
                    if (i_eng_done) begin
                        r_data  <= i_eng_data;
                        r_done  <= r_grant;
                        r_state <= RESP;
                    end else if (w_wd_inc == WD_W'(TIMEOUT - 1)) begin
                        r_data  <= '0;
                        r_done  <= r_grant;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_rr_ptr <= w_rr_next;
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_data      = r_data;
    assign o_busy      = r_busy;
    assign o_eng_start = r_eng_start;
    assign o_eng_data  = r_job;

endmodule
